// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W          = 5;  // register index width
  localparam int CNT_W          = 2;  // bubble counter width
  localparam int LU_BUBBLES_MIN = 1;
  localparam int LU_BUBBLES_MAX = 3;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_e;

  // Control bundle driven toward PC, IF/ID and ID/EX.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b0, id_flush: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0, id_flush: 1'b1};
  localparam ctrl_t CTRL_REDIR = '{pc_write: 1'b1, if_id_write: 1'b1, if_flush: 1'b1, id_flush: 1'b1};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b1, id_flush: 1'b1};

  // Load in EX writes a register that the ID instruction really reads.
  // x0 is never a true dependency.
  function automatic logic load_use(input logic             mem_read,
                                    input logic [REG_W-1:0] wr,
                                    input logic [REG_W-1:0] rs1,
                                    input logic [REG_W-1:0] rs2,
                                    input logic             use_rs1,
                                    input logic             use_rs2);
    return mem_read & (wr != '0) & ((use_rs1 & (rs1 == wr)) | (use_rs2 & (rs2 == wr)));
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter with enable and synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins; otherwise count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and branch/jump redirect controller.
// Optional statistics counters built when HAZARD_STATS_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int LOADUSE_BUBBLES = 1,
  parameter int STAT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_MemRead_i,
  input  logic [REG_W-1:0] id_ex_wr_i,
  input  logic [REG_W-1:0] if_id_rs1_i,
  input  logic [REG_W-1:0] if_id_rs2_i,
  input  logic             if_id_use_rs1_i,
  input  logic             if_id_use_rs2_i,
  input  logic             redirect_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             IF_Flush_o,
  output logic             ID_Flush_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles_o,
  output logic [STAT_W-1:0] redirects_o
`endif
);

  if ((LOADUSE_BUBBLES < LU_BUBBLES_MIN) || (LOADUSE_BUBBLES > LU_BUBBLES_MAX)) begin : g_bad_bubbles
    $error("hazard_unit: LOADUSE_BUBBLES out of range");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOADUSE_BUBBLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             hz;

  assign hz = load_use(id_ex_MemRead_i, id_ex_wr_i, if_id_rs1_i, if_id_rs2_i,
                       if_id_use_rs1_i, if_id_use_rs2_i);

  // State and bubble counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and controls; reset > redirect > stall.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      ctrl    = CTRL_RESET;
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (redirect_i) begin
      // Squash wrong path; also abandons any stall in progress.
      ctrl    = CTRL_REDIR;
      state_d = S_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (hz) begin
            ctrl = CTRL_STALL;
            if (LOADUSE_BUBBLES > 1) begin
              state_d = S_STALL;
              cnt_d   = CNT_INIT;
            end
          end
        end
        S_STALL: begin
          // hz ignored here: the bubble already in ID/EX resolves it.
          ctrl  = CTRL_STALL;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1))
            state_d = S_RUN;
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pc_write_o    = ctrl.pc_write;
  assign if_id_write_o = ctrl.if_id_write;
  assign IF_Flush_o    = ctrl.if_flush;
  assign ID_Flush_o    = ctrl.id_flush;

`ifdef HAZARD_STATS_EN
  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (~ctrl.pc_write),
    .count (stall_cycles_o)
  );

  sat_counter #(.W(STAT_W)) u_redir_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (redirect_i),
    .count (redirects_o)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table on a 1-bubble instance,
// hand sequences for a 3-bubble instance; stats checks when
// HAZARD_STATS_EN is defined.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic [4:0] wr, rs1, rs2;
  logic       use1, use2, redirect;

  logic pc1, ifid1, iff1, idf1;
  logic pc3, ifid3, iff3, idf3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  logic [31:0] st1, rd1, st3, rd3;
  logic [3:0]  st4, rd4;
  logic        pc4, ifid4, iff4, idf4;
`endif

  hazard_unit #(.LOADUSE_BUBBLES(1)) u1 (
    .clk(clk), .rst(rst), .id_ex_MemRead_i(mem_read), .id_ex_wr_i(wr),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_use_rs1_i(use1),
    .if_id_use_rs2_i(use2), .redirect_i(redirect),
    .pc_write_o(pc1), .if_id_write_o(ifid1), .IF_Flush_o(iff1), .ID_Flush_o(idf1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles_o(st1), .redirects_o(rd1)
`endif
  );

  hazard_unit #(.LOADUSE_BUBBLES(3)) u3 (
    .clk(clk), .rst(rst), .id_ex_MemRead_i(mem_read), .id_ex_wr_i(wr),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_use_rs1_i(use1),
    .if_id_use_rs2_i(use2), .redirect_i(redirect),
    .pc_write_o(pc3), .if_id_write_o(ifid3), .IF_Flush_o(iff3), .ID_Flush_o(idf3)
`ifdef HAZARD_STATS_EN
    , .stall_cycles_o(st3), .redirects_o(rd3)
`endif
  );

`ifdef HAZARD_STATS_EN
  hazard_unit #(.LOADUSE_BUBBLES(1), .STAT_W(4)) u4 (
    .clk(clk), .rst(rst), .id_ex_MemRead_i(mem_read), .id_ex_wr_i(wr),
    .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_use_rs1_i(use1),
    .if_id_use_rs2_i(use2), .redirect_i(redirect),
    .pc_write_o(pc4), .if_id_write_o(ifid4), .IF_Flush_o(iff4), .ID_Flush_o(idf4),
    .stall_cycles_o(st4), .redirects_o(rd4)
  );
`endif

  // {pc_write, if_id_write, IF_Flush, ID_Flush}
  localparam logic [3:0] E_RUN   = 4'b1100;
  localparam logic [3:0] E_STALL = 4'b0001;
  localparam logic [3:0] E_REDIR = 4'b1111;
  localparam logic [3:0] E_RESET = 4'b0011;

  typedef struct {
    logic       mr;
    logic [4:0] wr, rs1, rs2;
    logic       u1, u2, rd;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [4:0] w, input logic [4:0] a,
                       input logic [4:0] b, input logic ua, input logic ub, input logic r);
    mem_read = m; wr = w; rs1 = a; rs2 = b; use1 = ua; use2 = ub; redirect = r;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hz_in();
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    next(); next();
    rst = 1'b0;
  endtask

  int exp_st1, exp_rd1;

  initial begin
    vecs[0]  = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, E_RUN,   "no_load"};
    vecs[1]  = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0, E_STALL, "lu_rs2"};
    vecs[2]  = '{1'b0, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0, E_RUN,   "resume"};
    vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, E_RUN,   "wr_x0"};
    vecs[4]  = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 1'b0, E_RUN,   "no_use_rs1"};
    vecs[5]  = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, E_STALL, "lu_rs1"};
    vecs[6]  = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b1, E_REDIR, "redir_hz"};
    vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, E_REDIR, "redir1"};
    vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, E_REDIR, "redir2"};
    vecs[9]  = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, E_STALL, "lu_both"};
    vecs[10] = '{1'b1, 5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b0, E_RUN,   "no_use_rs2"};

    rst = 1'b1; idle();
    #1;
    // Reset held two cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("reset_u1_%0d", i), {28'd0, pc1, ifid1, iff1, idf1}, {28'd0, E_RESET});
      chk($sformatf("reset_u3_%0d", i), {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_RESET});
      next();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_u1", {28'd0, pc1, ifid1, iff1, idf1}, {28'd0, E_RUN});
`ifdef HAZARD_STATS_EN
    chk("post_reset_st1", st1, 0);
    chk("post_reset_rd1", rd1, 0);
`endif
    next();

    // Vector table on the single-bubble instance.
    exp_st1 = 0; exp_rd1 = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].mr, vecs[i].wr, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd);
      @(negedge clk);
      chk(vecs[i].nm, {28'd0, pc1, ifid1, iff1, idf1}, {28'd0, vecs[i].exp});
      if (vecs[i].exp[3] == 1'b0) exp_st1++;
      if (vecs[i].rd) exp_rd1++;
      next();
    end
    idle();
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    chk("tbl_st1", st1, exp_st1);
    chk("tbl_rd1", rd1, exp_rd1);
    next();
`endif

    // Three-bubble load-use: one hazard cycle, then three stalls total.
    do_reset();
    hz_in();
    @(negedge clk);
    chk("lu3_c0", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
    chk("lu1_c0", {28'd0, pc1, ifid1, iff1, idf1}, {28'd0, E_STALL});
    next();
    mem_read = 1'b0;
    @(negedge clk);
    chk("lu3_c1", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
    chk("lu1_c1", {28'd0, pc1, ifid1, iff1, idf1}, {28'd0, E_RUN});
    next();
    @(negedge clk);
    chk("lu3_c2", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
    next();
    @(negedge clk);
    chk("lu3_c3", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_RUN});
`ifdef HAZARD_STATS_EN
    chk("lu3_st3", st3, 3);
    chk("lu1_st1", st1, 1);
`endif
    next();

    // Hazard held through the stall is ignored; stall still ends after 3.
    do_reset();
    hz_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("lu3h_c%0d", i), {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
      next();
    end
    @(negedge clk);
    chk("lu3h_rehz", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
    next();

    // Redirect in the second stall cycle aborts the stall.
    do_reset();
    hz_in();
    @(negedge clk);
    chk("rds_c0", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
    next();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rds_c1", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_REDIR});
    next();
    idle();
    @(negedge clk);
    chk("rds_c2", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_RUN});
`ifdef HAZARD_STATS_EN
    chk("rds_rd3", rd3, 1);
    chk("rds_st3", st3, 1);
`endif
    next();
    @(negedge clk);
    chk("rds_c3", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_RUN});
    next();

    // Reset mid-stall abandons it.
    do_reset();
    hz_in();
    @(negedge clk);
    chk("rms_c0", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_STALL});
    next();
    rst = 1'b1; idle();
    @(negedge clk);
    chk("rms_rst", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_RESET});
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("rms_run", {28'd0, pc3, ifid3, iff3, idf3}, {28'd0, E_RUN});
    next();

`ifdef HAZARD_STATS_EN
    // 4-bit stall counter saturates at 15.
    do_reset();
    hz_in();
    for (int i = 0; i < 20; i++) next();
    @(negedge clk);
    chk("sat_20", {28'd0, st4}, 15);
    next(); next();
    @(negedge clk);
    chk("sat_hold", {28'd0, st4}, 15);
    chk("sat_rd", {28'd0, rd4}, 0);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0; idle();
    @(negedge clk);
    chk("sat_clr", {28'd0, st4}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
